// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the common baud divide factor.
// The transmitter imports the same CLOCKS_PER_BIT so both ends always agree.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int CLOCKS_PER_BIT = 5000;  // 48 MHz / 9600 bps

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RESET_VAL lets an idle-high line come out of reset without a false edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge, giving a true two-stage delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, single-cycle valid / framing-error strobes,
// and a BREAK state that holds off restarts while the line is stuck low.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       busy
);

  import uart_pkg::*;

  localparam int                CNT_W     = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 framing_error_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (serial_in),
    .q_o  (rx_s)
  );

  // cnt restarts at every state entry and at every mid-bit sample, so in DATA
  // it spans exactly one bit period between samples for any divide factor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      cnt_q           <= cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;  // high at mid-start is a glitch
          end
        end

        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == IDX_LAST) state_q <= STOP;
          end
        end

        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= BREAK;
            end
          end
        end

        BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLOCKS_PER_BIT=8: a bit-level transmitter
// task feeds the line and a scoreboard queue holds the bytes expected back.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       busy;

  int total;
  int bad;
  int v_cnt;
  int fe_cnt;
  logic prev_v;
  logic prev_fe;
  logic [7:0] sb[$];

  uart_rx #(
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bench-side transmitter: start bit, LSB-first data, one stop bit of chosen level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) sb.push_back(b);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every valid strobe and polices strobe shape.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        v_cnt++;
        if (sb.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
        check("valid_1clk", {31'd0, prev_v}, 32'd0);
      end
      if (framing_error) begin
        fe_cnt++;
        check("fe_1clk", {31'd0, prev_fe}, 32'd0);
      end
      if (rx_valid || framing_error)
        check("strobe_excl", {31'd0, rx_valid & framing_error}, 32'd0);
    end
    prev_v  = rx_valid;
    prev_fe = framing_error;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int fe0;
    int busy_low;
    logic seen_busy;
    logic [7:0] b;

    total = 0; bad = 0; v_cnt = 0; fe_cnt = 0;
    prev_v = 1'b0; prev_fe = 1'b0;
    reset = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle line after reset
    repeat (100) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_no_valid", v_cnt, 0);
    check("rst_no_fe", fe_cnt, 0);

    // Back-to-back frames
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_valid_cnt", v_cnt, 2);
    check("b2b_fe_cnt", fe_cnt, 0);
    check("b2b_last_data", {24'd0, rx_data}, 32'hA3);
    check("b2b_sb_empty", sb.size(), 0);

    // Two-clock low glitch must abort in START
    v0 = v_cnt;
    seen_busy = 1'b0;
    serial_in = 1'b0;
    repeat (2) @(negedge clk);
    serial_in = 1'b1;
    for (int i = 0; i < CPB / 2 + 5; i++) begin
      @(negedge clk);
      seen_busy |= busy;
    end
    check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", v_cnt, v0);
    check("glitch_no_fe", fe_cnt, 0);

    // Framing error, then stuck-low line held in BREAK
    v0 = v_cnt;
    send_frame(8'h3C, 1'b0);
    busy_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    check("fe_once", fe_cnt, 1);
    check("fe_no_valid", v_cnt, v0);
    check("fe_data_kept", {24'd0, rx_data}, 32'hA3);
    check("break_hold", busy_low, 0);
    serial_in = 1'b1;
    repeat (6) @(negedge clk);
    check("break_exit", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("after_break_data", {24'd0, rx_data}, 32'h81);

    // Reset in the middle of data bit 4 of 0xFF
    v0 = v_cnt;
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("midrst_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_fe", {31'd0, framing_error}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("midrst_no_valid", v_cnt, v0);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    check("midrst_next_data", {24'd0, rx_data}, 32'h0F);

    // Loopback of 256 random bytes, back-to-back
    v0 = v_cnt;
    fe0 = fe_cnt;
    b = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
    end
    repeat (3 * CPB) @(negedge clk);
    check("loop_valid_cnt", v_cnt - v0, 256);
    check("loop_no_fe", fe_cnt, fe0);
    check("loop_last_data", {24'd0, rx_data}, {24'd0, b});
    check("final_sb_empty", sb.size(), 0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
